uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter among N byte requesters. Grants one requester at a time, latches its byte, pulses the transmitter's start input, waits for frame completion (with timeout), then enforces a programmable inter-frame gap before the next grant. Sits between the client blocks and the transmitter FSM/datapath, and is the only driver of the transmitter's start and data inputs.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Client/transmitter-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   i_req;
    logic [8*N-1:0] i_data;
    logic [N-1:0]   o_ack;
    logic [7:0]     o_tx_data;
    logic           o_tx_start;
    logic           i_tx_done;
    logic           o_busy;
    logic [IDW-1:0] o_owner;
    logic           o_timeout;

    modport slave (
        input  i_req, i_data, i_tx_done,
        output o_ack, o_tx_data, o_tx_start, o_busy, o_owner, o_timeout
    );

    modport master (
        output i_req, i_data, i_tx_done,
        input  o_ack, o_tx_data, o_tx_start, o_busy, o_owner, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N byte requesters,
// with frame timeout and a programmable inter-frame gap.
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  T_MAX  = TW'(TIMEOUT);
    localparam logic [GW-1:0]  G_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [IDW-1:0] I_LAST = IDW'(N - 1);
    localparam logic [IDW:0]   N_W    = (IDW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam state_t POST_ST = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t         state_r;
    state_t         state_nx_s;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] owner_r;
    logic [IDW-1:0] win_s;
    logic [IDW:0]   sum_s;
    logic           hit_s;
    logic           found_s;
    logic           expire_s;
    logic [TW-1:0]  tcnt_r;
    logic [GW-1:0]  gcnt_r;
    logic [7:0]     tx_data_r;
    logic [N-1:0]   ack_r;
    logic           start_r;
    logic           busy_r;
    logic           timeout_r;

    // Round-robin winner: first active request at or above ptr, wrapping mod N.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        sum_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum_s   = {1'b0, ptr_r} + (IDW + 1)'(i);
            sum_s   = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
            hit_s   = bus.i_req[sum_s[IDW-1:0]];
            win_s   = (!found_s && hit_s) ? sum_s[IDW-1:0] : win_s;
            found_s = found_s | hit_s;
        end
    end

    // Next-state logic; expire_s flags the edge at which the wait counter hits TIMEOUT.
    always_comb begin
        state_nx_s = state_r;
        expire_s   = 1'b0;
        case (state_r)
            IDLE: state_nx_s = found_s ? LOAD : IDLE;
            LOAD: state_nx_s = WAIT;
            WAIT: begin
                if (tcnt_r == T_MAX) begin
                    state_nx_s = POST_ST;
                end else if (bus.i_tx_done) begin
                    // done on the expiry edge wins over the timeout
                    state_nx_s = POST_ST;
                end else begin
                    state_nx_s = WAIT;
                    expire_s   = (tcnt_r == T_LAST);
                end
            end
            GAP:     state_nx_s = (gcnt_r == G_LAST) ? IDLE : GAP;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, counters, captured byte/owner and registered strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            owner_r   <= '0;
            tx_data_r <= 8'h00;
            tcnt_r    <= '0;
            gcnt_r    <= '0;
            ack_r     <= '0;
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            start_r   <= (state_nx_s == LOAD);
            busy_r    <= (state_nx_s != IDLE);
            timeout_r <= expire_s;
            if (state_r == IDLE && found_s) begin
                owner_r   <= win_s;
                tx_data_r <= bus.i_data[{win_s, 3'b000} +: 8];
                ack_r     <= N'(1) << win_s;
            end else begin
                ack_r     <= '0;
            end
            if (state_r == LOAD) begin
                ptr_r <= (owner_r == I_LAST) ? '0 : owner_r + IDW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            // counting starts in LOAD so the count equals clocks since LOAD
            if (state_r == LOAD || state_r == WAIT) begin
                tcnt_r <= tcnt_r + TW'(1);
            end else begin
                tcnt_r <= '0;
            end
            if (state_r == GAP) begin
                gcnt_r <= gcnt_r + GW'(1);
            end else begin
                gcnt_r <= '0;
            end
        end
    end

    assign bus.o_ack      = ack_r;
    assign bus.o_tx_data  = tx_data_r;
    assign bus.o_tx_start = start_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_owner    = owner_r;
    assign bus.o_timeout  = timeout_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N=4, GAP_CYCLES=3, TIMEOUT=8).
module tb_uart_tx_arbiter;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   lat;

    int         order [5] = '{3, 0, 1, 2, 3};
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

    uart_tx_arbiter_if #(.N(4)) bus ();

    uart_tx_arbiter #(
        .N(4),
        .GAP_CYCLES(3),
        .TIMEOUT(8)
    ) u_dut (
        .i_clk(clk),
        .i_reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (bus.o_tx_start !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset         = 1'b1;
        bus.i_req     = 4'b1111;
        bus.i_data    = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.i_tx_done = 1'b0;

        // reset held with all requests active
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("rst_start", 32'(bus.o_tx_start), 32'd0);
            chk("rst_busy", 32'(bus.o_busy), 32'd0);
        end
        chk("rst_ack", 32'(bus.o_ack), 32'd0);
        chk("rst_data", 32'(bus.o_tx_data), 32'h00);
        chk("rst_owner", 32'(bus.o_owner), 32'd0);
        chk("rst_timeout", 32'(bus.o_timeout), 32'd0);
        bus.i_req = 4'b0000;
        reset     = 1'b0;
        tick(1);
        chk("idle_busy", 32'(bus.o_busy), 32'd0);

        // single request from requester 2
        bus.i_req = 4'b0100;
        tick(1);
        chk("single_start", 32'(bus.o_tx_start), 32'd1);
        chk("single_ack", 32'(bus.o_ack), 32'h4);
        chk("single_data", 32'(bus.o_tx_data), 32'hA5);
        chk("single_owner", 32'(bus.o_owner), 32'd2);
        chk("single_busy", 32'(bus.o_busy), 32'd1);
        bus.i_req = 4'b0000;
        tick(1);
        chk("single_start_off", 32'(bus.o_tx_start), 32'd0);
        chk("single_ack_off", 32'(bus.o_ack), 32'd0);
        bus.i_tx_done = 1'b1;
        tick(1);
        bus.i_tx_done = 1'b0;
        chk("single_gap_busy", 32'(bus.o_busy), 32'd1);
        tick(2);
        chk("single_gap_end_busy", 32'(bus.o_busy), 32'd1);
        tick(1);
        chk("single_idle_busy", 32'(bus.o_busy), 32'd0);
        chk("single_hold_data", 32'(bus.o_tx_data), 32'hA5);
        chk("single_hold_owner", 32'(bus.o_owner), 32'd2);

        // spurious done in IDLE
        bus.i_tx_done = 1'b1;
        tick(1);
        bus.i_tx_done = 1'b0;
        chk("spur_idle_busy", 32'(bus.o_busy), 32'd0);
        chk("spur_idle_start", 32'(bus.o_tx_start), 32'd0);

        // fairness: all request continuously, ptr sits at 3 after the single grant
        bus.i_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(lat);
            chk("fair_start", 32'(bus.o_tx_start), 32'd1);
            chk("fair_latency", 32'(lat), (k == 0) ? 32'd1 : 32'd4);
            chk("fair_owner", 32'(bus.o_owner), 32'(order[k]));
            chk("fair_ack", 32'(bus.o_ack), 32'd1 << order[k]);
            chk("fair_data", 32'(bus.o_tx_data), 32'(bytes[order[k]]));
            tick(1);
            chk("fair_ack_pulse", 32'(bus.o_ack), 32'd0);
            chk("fair_start_pulse", 32'(bus.o_tx_start), 32'd0);
            tick(3);
            bus.i_tx_done = 1'b1;
            tick(1);
            bus.i_tx_done = 1'b0;
            chk("fair_no_timeout", 32'(bus.o_timeout), 32'd0);
        end
        bus.i_req = 4'b0000;

        // spurious done in GAP must not restart the gap
        bus.i_tx_done = 1'b1;
        tick(1);
        bus.i_tx_done = 1'b0;
        tick(1);
        chk("spur_gap_busy", 32'(bus.o_busy), 32'd1);
        tick(1);
        chk("spur_gap_idle", 32'(bus.o_busy), 32'd0);

        // timeout: requester 1, no done
        bus.i_req = 4'b0010;
        tick(1);
        chk("to_owner", 32'(bus.o_owner), 32'd1);
        bus.i_req = 4'b0000;
        tick(7);
        chk("to_early", 32'(bus.o_timeout), 32'd0);
        tick(1);
        chk("to_pulse", 32'(bus.o_timeout), 32'd1);
        chk("to_pulse_busy", 32'(bus.o_busy), 32'd1);
        tick(1);
        chk("to_pulse_off", 32'(bus.o_timeout), 32'd0);
        chk("to_gap_busy", 32'(bus.o_busy), 32'd1);
        bus.i_req = 4'b0001;
        tick(2);
        chk("to_gap_ignores_req", 32'(bus.o_tx_start), 32'd0);
        tick(1);
        chk("to_idle_busy", 32'(bus.o_busy), 32'd0);
        tick(1);
        chk("to_next_start", 32'(bus.o_tx_start), 32'd1);
        chk("to_next_owner", 32'(bus.o_owner), 32'd0);
        chk("to_next_ack", 32'(bus.o_ack), 32'h1);
        bus.i_req = 4'b0000;

        // done on the expiry edge: done wins
        tick(7);
        bus.i_tx_done = 1'b1;
        tick(1);
        bus.i_tx_done = 1'b0;
        chk("race_no_timeout", 32'(bus.o_timeout), 32'd0);
        chk("race_gap_busy", 32'(bus.o_busy), 32'd1);
        tick(1);
        chk("race_no_late_timeout", 32'(bus.o_timeout), 32'd0);
        tick(2);
        chk("race_idle_busy", 32'(bus.o_busy), 32'd0);

        // reset mid-WAIT
        bus.i_req = 4'b0011;
        tick(1);
        chk("mid_owner", 32'(bus.o_owner), 32'd1);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_ack", 32'(bus.o_ack), 32'd0);
        chk("mid_rst_timeout", 32'(bus.o_timeout), 32'd0);
        chk("mid_rst_owner", 32'(bus.o_owner), 32'd0);
        chk("mid_rst_data", 32'(bus.o_tx_data), 32'h00);
        reset = 1'b0;
        tick(1);
        chk("post_rst_start", 32'(bus.o_tx_start), 32'd1);
        chk("post_rst_owner", 32'(bus.o_owner), 32'd0);
        chk("post_rst_ack", 32'(bus.o_ack), 32'h1);
        chk("post_rst_data", 32'(bus.o_tx_data), 32'h11);
        bus.i_req = 4'b0000;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
